ts_fm_sched: RTL

- Write scheduler and chip selector for a TurboSound-FM pair of YM2203 wrappers.
- Captures CPU port writes into a small FIFO.
- Decodes chip-select/FM-enable control bytes.
- Replays the remaining writes to the selected YM2203, spacing them by the programmable settle gaps that the FM core needs.
- Sits between the CPU port decoder and two YM2203 instances.

---
 rtl/ts_fm_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ts_fm_sched.sv
// ts_fm_sched: write scheduler and chip selector for a TurboSound-FM pair of YM2203s.
//
// CPU writes are posted into a small FIFO and replayed one at a time to the selected
// chip. After each replayed write, the scheduler waits a settle gap counted in CE_YM
// ticks before it issues the next one. A write of 0b11111xxx to the address port is a
// control byte: it updates SEL and FM_ENA and is never forwarded to a chip.
//
// Ports:
//   CLK, RESET_N        clock, synchronous active-low reset
//   CE_CPU, CPU_WR      posted write strobe; CPU_A0 selects the port, CPU_DI is the data
//   CPU_RD, CPU_DO      read request; combinational read data from the selected chip
//   CPU_WAIT            stall while the FIFO is full or while a read waits for writes to drain
//   CE_YM               tick that counts down the settle gap
//   YM_A0, YM_DI        shared bus to both chips (registered, holds its last issued value)
//   YM0_WE, YM1_WE      one-cycle write strobes
//   YM0_DO, YM1_DO      chip read data
//   FM_ENA, SEL, DROP   FM enable, selected chip, sticky overflow flag
module ts_fm_sched #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_GAP = 4,
  parameter int unsigned DATA_GAP = 24
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE_CPU,
  input  logic       CE_YM,
  input  logic       CPU_WR,
  input  logic       CPU_RD,
  input  logic       CPU_A0,
  input  logic [7:0] CPU_DI,
  output logic [7:0] CPU_DO,
  output logic       CPU_WAIT,
  output logic       YM_A0,
  output logic [7:0] YM_DI,
  output logic       YM0_WE,
  output logic       YM1_WE,
  input  logic [7:0] YM0_DO,
  input  logic [7:0] YM1_DO,
  output logic       FM_ENA,
  output logic       SEL,
  output logic       DROP
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned MaxGap = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
  localparam int unsigned GW     = (MaxGap == 0) ? 1 : $clog2(MaxGap + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            sel_q, sel_d;
  logic            fm_ena_q, fm_ena_d;
  logic            drop_q;
  logic            we0_q, we0_d, we1_q, we1_d;
  logic            ym_a0_q, ym_a0_d;
  logic [7:0]      ym_di_q, ym_di_d;

  logic            full, push, push_ok, pop, is_ctrl;
  logic [8:0]      head;

  // Fullness is judged on the registered count, so a pop in the same cycle cannot rescue
  // a push into a full FIFO.
  assign full    = (count_q == CW'(DEPTH));
  assign push    = CE_CPU & CPU_WR;
  assign push_ok = push & ~full;
  assign pop     = (state_q == StIssue);
  assign head    = mem_q[rd_ptr_q];
  assign is_ctrl = ~head[8] & (head[7:3] == 5'b11111);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    sel_d    = sel_q;
    fm_ena_d = fm_ena_q;
    we0_d    = 1'b0;
    we1_d    = 1'b0;
    ym_a0_d  = ym_a0_q;
    ym_di_d  = ym_di_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StIssue;
      end
      StIssue: begin
        if (is_ctrl) begin
          // Control bytes retarget later writes only; nothing reaches the chips.
          sel_d    = ~head[0];
          fm_ena_d = ~head[2];
          state_d  = StIdle;
        end else begin
          ym_a0_d = head[8];
          ym_di_d = head[7:0];
          we0_d   = ~sel_q;
          we1_d   = sel_q;
          gap_d   = head[8] ? GW'(DATA_GAP) : GW'(ADDR_GAP);
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else if (CE_YM) gap_d = gap_q - GW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {CPU_A0, CPU_DI};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      sel_q    <= 1'b0;
      fm_ena_q <= 1'b1;
      drop_q   <= 1'b0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      ym_a0_q  <= 1'b0;
      ym_di_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      sel_q    <= sel_d;
      fm_ena_q <= fm_ena_d;
      we0_q    <= we0_d;
      we1_q    <= we1_d;
      ym_a0_q  <= ym_a0_d;
      ym_di_q  <= ym_di_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push & full) drop_q <= 1'b1;
    end
  end

  assign CPU_DO   = sel_q ? YM1_DO : YM0_DO;
  // A read stalls until every earlier posted write has been issued and has settled.
  assign CPU_WAIT = full | (CPU_RD & ((count_q != '0) | (state_q != StIdle)));
  assign YM_A0    = ym_a0_q;
  assign YM_DI    = ym_di_q;
  assign YM0_WE   = we0_q;
  assign YM1_WE   = we1_q;
  assign FM_ENA   = fm_ena_q;
  assign SEL      = sel_q;
  assign DROP     = drop_q;

endmodule
